bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master (CPU = m0, DMA = m1) single-slave bus arbiter with optional locked bursts.
// Define BUS_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module bus_arbiter #(
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        s_sel,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS0 = 3'd1,
    ACCESS1 = 3'd2,
    RESP0   = 3'd3,
    RESP1   = 3'd4
  } state_t;

  localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

  state_t      state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic        last_gnt_q, last_gnt_d;
  logic        m0_gnt_q, m1_gnt_q;
  logic        m0_done_q, m1_done_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;
  logic        win_m1;
  logic        in_access;
  logic        sel_m1;

`ifdef BUS_ARB_RR_EN
  // On a tie the master that did not hold the bus last goes first.
  assign win_m1 = m1_req & (~m0_req | ~last_gnt_q);
`else
  assign win_m1 = m1_req & ~m0_req;
`endif

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d = win_m1 ? ACCESS1 : ACCESS0;
        end
      end
      ACCESS0: begin
        beat_d  = beat_q + 4'd1;
        state_d = RESP0;
      end
      ACCESS1: begin
        beat_d  = beat_q + 4'd1;
        state_d = RESP1;
      end
      RESP0: begin
        if (m0_lock && m0_req && (beat_q < MAX_LOCK_C)) begin
          state_d = ACCESS0;
        end else begin
          state_d    = IDLE;
          beat_d     = 4'd0;
          last_gnt_d = 1'b0;
        end
      end
      RESP1: begin
        if (m1_lock && m1_req && (beat_q < MAX_LOCK_C)) begin
          state_d = ACCESS1;
        end else begin
          state_d    = IDLE;
          beat_d     = 4'd0;
          last_gnt_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = 4'd0;
      end
    endcase
  end

  // gnt/done are registered from the next state so they line up with ACCESSn/RESPn.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= 4'd0;
      last_gnt_q <= 1'b1;
      m0_gnt_q   <= 1'b0;
      m1_gnt_q   <= 1'b0;
      m0_done_q  <= 1'b0;
      m1_done_q  <= 1'b0;
      m0_rdata_q <= 32'd0;
      m1_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      last_gnt_q <= last_gnt_d;
      m0_gnt_q   <= (state_d == ACCESS0);
      m1_gnt_q   <= (state_d == ACCESS1);
      m0_done_q  <= (state_d == RESP0);
      m1_done_q  <= (state_d == RESP1);
      if (state_q == ACCESS0 && !m0_we) begin
        m0_rdata_q <= s_rdata;
      end
      if (state_q == ACCESS1 && !m1_we) begin
        m1_rdata_q <= s_rdata;
      end
    end
  end

  // Gating with rst keeps the slave quiet in the cycle a reset is being sampled.
  assign in_access = ((state_q == ACCESS0) || (state_q == ACCESS1)) && rst;
  assign sel_m1    = (state_q == ACCESS1);

  always_comb begin
    s_sel   = in_access;
    s_we    = 1'b0;
    s_addr  = 32'd0;
    s_wdata = 32'd0;
    if (in_access) begin
      s_we    = sel_m1 ? m1_we    : m0_we;
      s_addr  = sel_m1 ? m1_addr  : m0_addr;
      s_wdata = sel_m1 ? m1_wdata : m0_wdata;
    end
  end

  assign m0_gnt   = m0_gnt_q;
  assign m1_gnt   = m1_gnt_q;
  assign m0_done  = m0_done_q;
  assign m1_done  = m1_done_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

  a_gnt_excl: assert property (@(posedge clk) !(m0_gnt_q && m1_gnt_q));
  a_gnt_done0: assert property (@(posedge clk) !(m0_gnt_q && m0_done_q));
  a_gnt_done1: assert property (@(posedge clk) !(m1_gnt_q && m1_done_q));
  a_beat_max: assert property (@(posedge clk) disable iff (!rst) beat_q <= MAX_LOCK_C);
  a_last0: assert property (@(posedge clk) disable iff (!rst)
    (state_q == RESP0 && state_d == IDLE) |=> !last_gnt_q);
  a_last1: assert property (@(posedge clk) disable iff (!rst)
    (state_q == RESP1 && state_d == IDLE) |=> last_gnt_q);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized bench for bus_arbiter against a tenure-level reference model.
// Honours BUS_ARB_RR_EN the same way as the design.
module tb_bus_arbiter;
  localparam int ML = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req[2];
  logic        lock[2];
  logic        we[2];
  logic [31:0] addr[2];
  logic [31:0] wdata[2];
  logic        m0_gnt, m1_gnt, m0_done, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_sel, s_we;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: owner of the bus (-1 = free) and cycle index within its tenure.
  // Even tenure cycles are access beats, odd ones are completion cycles.
  int          own;
  int          tcyc;
  bit          last;
  logic [31:0] mrd[2];
  bit          pend[2];

  bus_arbiter #(.MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_lock(lock[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_lock(lock[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if (req[0] && req[1]) begin
`ifdef BUS_ARB_RR_EN
      return last ? 0 : 1;
`else
      return 0;
`endif
    end
    return req[0] ? 0 : 1;
  endfunction

  task automatic check_outputs();
    int o;
    bit acc, esel;
    o    = (own < 0) ? 0 : own;
    acc  = (own >= 0) && (tcyc % 2 == 0);
    esel = acc && rst;
    chk("m0_gnt",  32'(m0_gnt),  32'(acc && own == 0));
    chk("m1_gnt",  32'(m1_gnt),  32'(acc && own == 1));
    chk("m0_done", 32'(m0_done), 32'(own == 0 && tcyc % 2 == 1));
    chk("m1_done", 32'(m1_done), 32'(own == 1 && tcyc % 2 == 1));
    chk("s_sel",   32'(s_sel),   32'(esel));
    chk("s_we",    32'(s_we),    32'(esel && we[o]));
    chk("s_addr",  s_addr,  esel ? addr[o]  : 32'd0);
    chk("s_wdata", s_wdata, esel ? wdata[o] : 32'd0);
    chk("m0_rdata", m0_rdata, mrd[0]);
    chk("m1_rdata", m1_rdata, mrd[1]);
  endtask

  task automatic model_advance();
    if (!rst) begin
      own = -1; tcyc = 0; last = 1'b1; mrd[0] = 32'd0; mrd[1] = 32'd0;
    end else if (own < 0) begin
      if (req[0] || req[1]) begin
        own = pick(); tcyc = 0;
      end
    end else if (tcyc % 2 == 0) begin
      if (!we[own]) mrd[own] = s_rdata;
      tcyc++;
    end else if (lock[own] && req[own] && ((tcyc + 1) / 2 < ML)) begin
      tcyc++;
    end else begin
      last = (own == 1);
      own  = -1;
    end
  endtask

  task automatic cyc_check(); #1; check_outputs(); endtask
  task automatic cyc_end(); model_advance(); @(negedge clk); endtask
  task automatic step(); cyc_check(); cyc_end(); endtask

  task automatic rand_drive();
    for (int n = 0; n < 2; n++) begin
      bit dn;
      dn = (own == n) && (tcyc % 2 == 1);
      if (!pend[n]) begin
        if ($urandom_range(0, 3) == 0) begin
          req[n] = 1'b1; pend[n] = 1'b1;
        end else begin
          req[n] = 1'b0;
        end
        lock[n] = 1'($urandom_range(0, 1)); we[n] = 1'($urandom_range(0, 1));
        addr[n] = $urandom; wdata[n] = $urandom;
      end else if (dn) begin
        if ($urandom_range(0, 2) != 0) begin
          req[n] = 1'b1;
        end else begin
          req[n] = 1'b0; pend[n] = 1'b0;
        end
        lock[n] = 1'($urandom_range(0, 1)); we[n] = 1'($urandom_range(0, 1));
        addr[n] = $urandom; wdata[n] = $urandom;
      end
    end
    rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
    if (!rst) begin
      req[0] = 1'b0; req[1] = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0;
    end
    s_rdata = $urandom;
  endtask

  initial begin
    int wecnt;
    rst = 1'b0; s_rdata = 32'd0;
    for (int n = 0; n < 2; n++) begin
      req[n] = 1'b0; lock[n] = 1'b0; we[n] = 1'b0; addr[n] = 32'd0; wdata[n] = 32'd0;
      pend[n] = 1'b0;
    end
    own = -1; tcyc = 0; last = 1'b1; mrd[0] = 32'd0; mrd[1] = 32'd0;
    @(negedge clk);
    step(); step();
    rst = 1'b1;
    step();

    // Single m1 read: grant one cycle after request, done the next.
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0000_0010; wdata[1] = 32'h5555_AAAA;
    s_rdata = 32'hDEAD_BEEF;
    step();
    cyc_check();
    chk("rd_gnt", 32'(m1_gnt), 32'd1);
    chk("rd_addr", s_addr, 32'h10);
    chk("rd_we", 32'(s_we), 32'd0);
    cyc_end();
    req[1] = 1'b0;
    cyc_check();
    chk("rd_done", 32'(m1_done), 32'd1);
    chk("rd_data", m1_rdata, 32'hDEAD_BEEF);
    cyc_end();
    step();

    // Simultaneous requests held high across three tenures.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h20; lock[0] = 1'b0;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h24; lock[1] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      bit exp0;
`ifdef BUS_ARB_RR_EN
      exp0 = (t != 1);
`else
      exp0 = 1'b1;
`endif
      s_rdata = 32'h1000 + 32'(t);
      step();
      cyc_check();
      chk("tie_m0_gnt", 32'(m0_gnt), 32'(exp0));
      chk("tie_m1_gnt", 32'(m1_gnt), 32'(!exp0));
      cyc_end();
      step();
    end
    req[0] = 1'b0; req[1] = 1'b0;
    step();

    // Locked m0 write burst with m1 waiting.
    req[0] = 1'b1; lock[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h100; wdata[0] = 32'hCAFE_0000;
    step();
    req[1] = 1'b1; lock[1] = 1'b0; we[1] = 1'b0; addr[1] = 32'h200;
    for (int b = 0; b < ML; b++) begin
      cyc_check();
      chk("lock_gnt", 32'(m0_gnt), 32'd1);
      chk("lock_we", 32'(s_we), 32'd1);
      cyc_end();
      cyc_check();
      chk("lock_done", 32'(m0_done), 32'd1);
      cyc_end();
      wdata[0] = 32'hCAFE_0001 + 32'(b);
    end
    cyc_check();
    chk("lock_rel_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    cyc_end();
    cyc_check();
`ifdef BUS_ARB_RR_EN
    chk("lock_next_m1", 32'(m1_gnt), 32'd1);
`else
    chk("lock_next_m0", 32'(m0_gnt), 32'd1);
`endif
    cyc_end();
    req[0] = 1'b0; lock[0] = 1'b0; req[1] = 1'b0;
    step(); step(); step();

    // Reset landing in the access cycle of an m1 write.
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h300; wdata[1] = 32'h0BAD_F00D;
    step();
    rst = 1'b0;
    cyc_check();
    chk("rst_sel", 32'(s_sel), 32'd0);
    chk("rst_we", 32'(s_we), 32'd0);
    cyc_end();
    rst = 1'b1; req[1] = 1'b0;
    cyc_check();
    chk("rst_done", 32'(m1_done), 32'd0);
    chk("rst_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_rd1", m1_rdata, 32'd0);
    chk("rst_addr", s_addr, 32'd0);
    cyc_end();
    cyc_check();
    chk("rst_done2", 32'(m1_done), 32'd0);
    cyc_end();

    // m0 read, then an m0 write while m1 wiggles its unrequested inputs.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h40; lock[0] = 1'b0; s_rdata = 32'hA5A5_0001;
    step(); step();
    req[0] = 1'b0;
    step(); step();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h7F00; wdata[0] = 32'h1234_5678;
    req[1] = 1'b0; s_rdata = 32'h0F0F_0F0F;
    wecnt = 0;
    for (int i = 0; i < 5; i++) begin
      we[1] = 1'(i % 2); addr[1] = $urandom; wdata[1] = $urandom;
      if (i == 2) req[0] = 1'b0;
      cyc_check();
      if (s_we) wecnt++;
      if (i == 1) begin
        chk("wr_addr", s_addr, 32'h7F00);
        chk("wr_wdata", s_wdata, 32'h1234_5678);
        chk("wr_we", 32'(s_we), 32'd1);
      end
      cyc_end();
    end
    chk("wr_we_cycles", 32'(wecnt), 32'd1);
    chk("wr_rdata_kept", m0_rdata, 32'hA5A5_0001);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
